// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Bundles the signals around the fetch sequencer: redirect and
//               halt control from the PC datapath, the instruction-memory
//               request/response bus, and the valid/ready decode handoff.
//               master = fetch_ctrl side, slave = environment side.
// Ports       : redirect_i/redirect_pc_i/halt_i   control into fetch
//               imem_req_o/imem_addr_o/imem_gnt_i  request channel
//               imem_rvalid_i/imem_rdata_i         in-order response channel
//               if_valid_o/if_ready_i/if_pc_o/if_inst_o  decode handoff
//               busy_o                             responses outstanding
// Revision    : 1.0  initial release
// ============================================================================
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              halt_i;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [DATA_W-1:0] imem_rdata_i;
  logic              if_valid_o;
  logic              if_ready_i;
  logic [ADDR_W-1:0] if_pc_o;
  logic [DATA_W-1:0] if_inst_o;
  logic              busy_o;

  modport master (
    input  redirect_i, redirect_pc_i, halt_i,
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output if_valid_o, if_pc_o, if_inst_o,
    input  if_ready_i,
    output busy_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, halt_i,
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  if_valid_o, if_pc_o, if_inst_o,
    output if_ready_i,
    input  busy_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch sequencer. Owns the PC, issues in-order imem requests
//               under a credit limit of two (outstanding + buffered), pairs
//               each response with its request PC, drops responses made
//               stale by a redirect and buffers good ones in a 2-entry FIFO
//               toward decode.
// Ports       : clk  clock
//               rst  asynchronous reset, active low
//               bus  fetch_ctrl_if.master (control, imem, decode handoff)
// Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DATA_W   = 32
) (
  input  wire logic      clk,
  input  wire logic      rst,
  fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        out_cnt;
  logic [1:0]        kill_cnt;
  logic [1:0]        fifo_cnt;

  // request-PC queue: one slot per outstanding request, read in order
  logic [ADDR_W-1:0] pcq_mem [2];
  logic              pcq_wr, pcq_rd;

  // decode FIFO
  logic [ADDR_W-1:0] fifo_pc   [2];
  logic [DATA_W-1:0] fifo_inst [2];
  logic              fifo_wr, fifo_rd;

  logic redirect_act, credit_ok, req, grant, rsp, push, pop, fifo_nonempty;

  // Redirect has no effect during BOOT
  assign redirect_act  = bus.redirect_i & (state_q != BOOT);
  // Credit keeps every in-flight response guaranteed a FIFO slot
  assign credit_ok     = ({1'b0, out_cnt} + {1'b0, fifo_cnt}) < 3'd2;
  assign req           = (state_q == RUN) & ~bus.halt_i & ~bus.redirect_i & credit_ok;
  assign grant         = req & bus.imem_gnt_i;
  // a response with nothing outstanding is spurious and ignored
  assign rsp           = bus.imem_rvalid_i & (out_cnt != 2'd0);
  assign push          = rsp & (kill_cnt == 2'd0) & ~redirect_act;
  assign fifo_nonempty = (fifo_cnt != 2'd0);
  assign pop           = fifo_nonempty & bus.if_ready_i & ~redirect_act;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q;
  assign bus.busy_o      = (out_cnt != 2'd0);
  assign bus.if_valid_o  = fifo_nonempty;
  assign bus.if_pc_o     = fifo_nonempty ? fifo_pc[fifo_rd]   : '0;
  assign bus.if_inst_o   = fifo_nonempty ? fifo_inst[fifo_rd] : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.halt_i && (out_cnt == 2'd0)) state_d = HALT;
      HALT:    if (!bus.halt_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      out_cnt  <= 2'd0;
      kill_cnt <= 2'd0;
      fifo_cnt <= 2'd0;
      pcq_wr   <= 1'b0;
      pcq_rd   <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (redirect_act)
        pc_q <= bus.redirect_pc_i;
      else if (grant)
        pc_q <= pc_q + ADDR_W'(4);

      // grant is never high in a redirect cycle, so only rsp matters then
      case ({grant, rsp})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase

      if (grant) pcq_wr <= ~pcq_wr;
      if (rsp)   pcq_rd <= ~pcq_rd;

      // Everything still in flight after a redirect is stale; the response
      // arriving in the redirect cycle itself is dropped directly.
      if (redirect_act)
        kill_cnt <= out_cnt - {1'b0, rsp};
      else if (rsp && (kill_cnt != 2'd0))
        kill_cnt <= kill_cnt - 2'd1;

      if (redirect_act) begin
        fifo_cnt <= 2'd0;
        fifo_wr  <= 1'b0;
        fifo_rd  <= 1'b0;
      end else begin
        if (push) fifo_wr <= ~fifo_wr;
        if (pop)  fifo_rd <= ~fifo_rd;
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
          2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (grant)
      pcq_mem[pcq_wr] <= pc_q;
    if (push) begin
      fifo_pc[fifo_wr]   <= pcq_mem[pcq_rd];
      fifo_inst[fifo_wr] <= bus.imem_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. An in-order imem model
//               with configurable latency answers granted requests; good
//               responses go onto a scoreboard queue and are compared when
//               decode accepts them. Redirects mark in-flight responses stale.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int                ADDR_W   = 32;
  localparam int                DATA_W   = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_ent_t;

  logic clk;
  logic rst;

  fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  mem_ent_t    pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          cyc;
  int          delivered;
  bit          got_first;
  logic [31:0] first_pc;
  logic [31:0] last_grant;
  bit          wrap_seen;
  bit          cfg_gnt, cfg_ready, cfg_halt;
  int          cfg_lat;
  logic        s_req, s_valid, s_busy;
  logic [31:0] s_pc, s_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_idle();
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.halt_i        = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.if_ready_i    = 1'b0;
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, update model
  task automatic tick(input bit redir, input logic [31:0] tgt);
    bit          rv;
    mem_ent_t    e;
    logic [31:0] p;
    @(negedge clk);
    rv = (pend.size() != 0) && (pend[0].due <= cyc);
    bus.redirect_i    = redir;
    bus.redirect_pc_i = tgt;
    bus.halt_i        = cfg_halt;
    bus.imem_gnt_i    = cfg_gnt;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? inst_of(pend[0].addr) : 32'h0;
    bus.if_ready_i    = cfg_ready;
    #1;
    s_req   = bus.imem_req_o;
    s_valid = bus.if_valid_o;
    s_busy  = bus.busy_o;
    s_pc    = bus.if_pc_o;
    s_addr  = bus.imem_addr_o;
    check_eq("busy", {31'b0, s_busy}, {31'b0, pend.size() != 0});
    check_eq("if_valid", {31'b0, s_valid}, {31'b0, exp_q.size() != 0});
    if (redir || cfg_halt)
      check_eq("req_blocked", {31'b0, s_req}, 32'h0);
    if (s_req && cfg_gnt) begin
      check_eq("imem_addr", s_addr, exp_pc);
      if (s_addr == 32'h0 && last_grant == 32'hFFFF_FFFC) wrap_seen = 1'b1;
      last_grant = s_addr;
      e.addr = s_addr; e.due = cyc + cfg_lat; e.stale = 1'b0;
      pend.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    if (s_valid && cfg_ready && !redir) begin
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check_eq("if_pc", s_pc, p);
        check_eq("if_inst", bus.if_inst_o, inst_of(p));
        if (!got_first) begin got_first = 1'b1; first_pc = s_pc; end
        delivered++;
      end else begin
        check_eq("unexpected_delivery", s_pc, 32'hFFFF_FFFF);
      end
    end
    if (rv) begin
      e = pend.pop_front();
      if (!e.stale && !redir) exp_q.push_back(e.addr);
    end
    if (redir) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_pc = tgt;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0);
  endtask

  // Reset the DUT and the model; release just after a rising edge so the
  // first sampled cycle is BOOT.
  task automatic do_reset();
    rst = 1'b0;
    drive_idle();
    @(posedge clk); #2;
    check_eq("rst_req",   {31'b0, bus.imem_req_o}, 32'h0);
    check_eq("rst_valid", {31'b0, bus.if_valid_o}, 32'h0);
    check_eq("rst_busy",  {31'b0, bus.busy_o},     32'h0);
    check_eq("rst_pc",    bus.if_pc_o,   32'h0);
    check_eq("rst_inst",  bus.if_inst_o, 32'h0);
    check_eq("rst_addr",  bus.imem_addr_o, RESET_PC);
    pend.delete(); exp_q.delete();
    exp_pc = RESET_PC; cyc = 0; delivered = 0; got_first = 1'b0;
    last_grant = 32'h0; wrap_seen = 1'b0;
    cfg_gnt = 1'b1; cfg_ready = 1'b1; cfg_halt = 1'b0; cfg_lat = 1;
    @(posedge clk); #2;
    rst = 1'b1;
    tick(1'b0, 32'h0);
    check_eq("boot_req", {31'b0, s_req}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive_idle();

    // Streaming with single-cycle memory latency
    do_reset();
    run(12);
    check_eq("t1_progress", {31'b0, delivered >= 5}, 32'h1);
    check_eq("t1_first_pc", first_pc, 32'h0);

    // Decode back-pressure: FIFO fills, requests stop, then drains in order
    do_reset();
    cfg_ready = 1'b0;
    run(10);
    check_eq("t2_req_stalled", {31'b0, s_req},   32'h0);
    check_eq("t2_valid_held",  {31'b0, s_valid}, 32'h1);
    check_eq("t2_head_pc",     s_pc, 32'h0);
    cfg_ready = 1'b1;
    run(10);
    check_eq("t2_progress", {31'b0, delivered >= 4}, 32'h1);

    // Redirect with two requests in flight
    do_reset();
    cfg_lat = 4;
    for (int i = 0; i < 20 && pend.size() != 2; i++) tick(1'b0, 32'h0);
    check_eq("t3_two_outstanding", pend.size(), 32'd2);
    got_first = 1'b0; delivered = 0;
    tick(1'b1, 32'h0000_0100);
    run(16);
    check_eq("t3_first_pc", first_pc, 32'h0000_0100);
    check_eq("t3_progress", {31'b0, delivered >= 2}, 32'h1);

    // Redirect coinciding with a response and a grant
    do_reset();
    cfg_lat = 2;
    for (int i = 0; i < 20 && !(pend.size() == 2 && pend[0].due <= cyc); i++) tick(1'b0, 32'h0);
    check_eq("t4_setup", {31'b0, pend.size() == 2 && pend[0].due <= cyc}, 32'h1);
    got_first = 1'b0; delivered = 0;
    tick(1'b1, 32'h0000_0200);
    tick(1'b0, 32'h0);
    check_eq("t4_busy_stale", {31'b0, s_busy}, 32'h1);
    run(10);
    check_eq("t4_first_pc", first_pc, 32'h0000_0200);

    // Halt with two requests in flight, then resume
    do_reset();
    cfg_lat = 3;
    for (int i = 0; i < 20 && pend.size() != 2; i++) tick(1'b0, 32'h0);
    check_eq("t5_two_outstanding", pend.size(), 32'd2);
    cfg_halt = 1'b1;
    run(8);
    check_eq("t5_delivered", delivered, 32'd2);
    check_eq("t5_busy",  {31'b0, s_busy}, 32'h0);
    check_eq("t5_req",   {31'b0, s_req},  32'h0);
    cfg_halt = 1'b0;
    run(10);
    check_eq("t5_resume", {31'b0, delivered >= 4}, 32'h1);

    // Asynchronous reset mid-stream, then PC wrap-around
    do_reset();
    run(6);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_eq("async_req",   {31'b0, bus.imem_req_o}, 32'h0);
    check_eq("async_valid", {31'b0, bus.if_valid_o}, 32'h0);
    check_eq("async_busy",  {31'b0, bus.busy_o},     32'h0);
    check_eq("async_pc",    bus.if_pc_o,   32'h0);
    check_eq("async_inst",  bus.if_inst_o, 32'h0);
    do_reset();
    check_eq("t6_boot_addr", s_addr, RESET_PC);
    tick(1'b0, 32'h0);
    tick(1'b1, 32'hFFFF_FFF8);
    run(10);
    check_eq("t6_wrap", {31'b0, wrap_seen}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
